// File: rtl/mux_seq_pkg.sv
// Shared constants and state encoding for the mux select sequencer.
package mux_seq_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  // Two-state FSM kept as plain constants so legacy tools can consume it.
  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t DWELL = 1'b1;

  // Reset pointer value; the search starts at ptr+1, so the first grant looks at channel 0 first.
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational channel picker: round-robin starting after ptr.
// Optional macro MUX_SEL_SEQ_FIXED_PRIO_EN selects lowest-index-wins fixed priority instead.
module rr_pick
  import mux_seq_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             found
);

`ifdef MUX_SEL_SEQ_FIXED_PRIO_EN
  // The pointer still exists at the interface but fixed priority ignores it.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the top down so the lowest requesting index is the last write and wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick  = SEL_W'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [SEL_W-1:0] w_idx;

  // Scan offsets N_CH..1 from ptr; the smallest offset is written last and wins.
  // Offset N_CH wraps to ptr itself, so a lone requester at ptr is re-granted.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    w_idx = '0;
    for (int i = N_CH; i >= 1; i--) begin
      w_idx = ptr + SEL_W'(i);
      if (req[w_idx]) begin
        pick  = w_idx;
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for the 4-channel mux: grants one requesting source at a time,
// holds the select for a programmable dwell, and releases it on consumer ack.
// Optional macro MUX_SEL_SEQ_FIXED_PRIO_EN switches arbitration to fixed priority.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_CH-1:0]    req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ack,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy
);

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;
  logic [DWELL_W-1:0] r_cnt;

  logic [SEL_W-1:0]   w_pick;
  logic               w_found;
  logic               w_grant;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (r_ptr),
    .pick  (w_pick),
    .found (w_found)
  );

  // A new grant is only possible when enabled and someone is requesting.
  assign w_grant = en && w_found;

  // Grant/dwell/release state machine; dwell is sampled only at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= PTR_RST;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= DWELL;
            r_sel   <= w_pick;
            r_ptr   <= w_pick;
            r_cnt   <= dwell;
          end
        end
        DWELL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end else if (ack) begin
            // Re-grant without an idle bubble when another grant is available.
            if (w_grant) begin
              r_sel <= w_pick;
              r_ptr <= w_pick;
              r_cnt <= dwell;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are straight from state so they are glitch-free to the consumer.
  always_comb begin
    sel       = r_sel;
    sel_valid = (r_state == DWELL);
    busy      = (r_state == DWELL);
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with an expectation queue.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] dwell;
  logic       ack;
  logic [1:0] sel;
  logic       sel_valid;
  logic       busy;

  typedef struct {
    logic [1:0] sel;
    logic       valid;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mux_sel_sequencer #(.DWELL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .dwell     (dwell),
    .ack       (ack),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue what must appear after the edge, then check it.
  task automatic cyc(input logic t_rst, input logic t_en, input logic [3:0] t_req,
                     input logic [3:0] t_dwell, input logic t_ack,
                     input logic [1:0] e_sel, input logic e_valid, input string tag);
    exp_t e;
    @(negedge clk);
    rst   = t_rst;
    en    = t_en;
    req   = t_req;
    dwell = t_dwell;
    ack   = t_ack;
    e.sel   = e_sel;
    e.valid = e_valid;
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    assert (sel === e.sel) else begin
      n_fail++;
      $error("FAIL %s sel: got %0d expected %0d", e.tag, sel, e.sel);
    end
    n_tests++;
    assert (sel_valid === e.valid) else begin
      n_fail++;
      $error("FAIL %s sel_valid: got %0b expected %0b", e.tag, sel_valid, e.valid);
    end
    n_tests++;
    assert (busy === e.valid) else begin
      n_fail++;
      $error("FAIL %s busy: got %0b expected %0b", e.tag, busy, e.valid);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0; dwell = 4'd0; ack = 1'b0;
    cyc(1, 0, 4'b0000, 0, 0, 2'd0, 0, "reset0");
    cyc(1, 0, 4'b0000, 0, 0, 2'd0, 0, "reset1");
`ifdef MUX_SEL_SEQ_FIXED_PRIO_EN
    // Fixed priority: channel 1 beats channel 3 every time.
    for (int i = 0; i < 6; i++) cyc(0, 1, 4'b1010, 0, 1, 2'd1, 1, "fixprio");
    cyc(0, 0, 4'b0000, 0, 1, 2'd1, 0, "fixprio_rel");
`else
    // Round-robin over all four with 1-cycle grants.
    cyc(0, 1, 4'b1111, 0, 1, 2'd0, 1, "rr_ch0");
    cyc(0, 1, 4'b1111, 0, 1, 2'd1, 1, "rr_ch1");
    cyc(0, 1, 4'b1111, 0, 1, 2'd2, 1, "rr_ch2");
    cyc(0, 1, 4'b1111, 0, 1, 2'd3, 1, "rr_ch3");
    cyc(0, 1, 4'b1111, 0, 1, 2'd0, 1, "rr_wrap");
    // Single requester, dwell=3: two back-to-back 4-cycle grants on channel 2.
    for (int i = 0; i < 8; i++) cyc(0, 1, 4'b0100, 3, 1, 2'd2, 1, "dwell3");
    // A dwell change mid-grant must not extend it: release after cnt ran out.
    cyc(0, 0, 4'b0000, 9, 1, 2'd2, 0, "release_idle");
    cyc(0, 0, 4'b0000, 0, 0, 2'd2, 0, "idle_hold_sel");
    // Stall with ack low, then release and wrap.
    cyc(1, 0, 4'b0000, 0, 0, 2'd0, 0, "reset2");
    for (int i = 0; i < 6; i++) cyc(0, 1, 4'b1001, 0, 0, 2'd0, 1, "stall");
    cyc(0, 1, 4'b1001, 0, 1, 2'd3, 1, "after_stall");
    cyc(0, 1, 4'b1001, 0, 1, 2'd0, 1, "wrap_back");
    // Grant ch2 with dwell 3, then drop en/req at cnt=2; grant still completes.
    cyc(0, 1, 4'b0100, 3, 1, 2'd2, 1, "mid_grant");
    cyc(0, 1, 4'b0100, 3, 1, 2'd2, 1, "mid_cnt2");
    cyc(0, 0, 4'b0000, 0, 1, 2'd2, 1, "mid_cnt1");
    cyc(0, 0, 4'b0000, 0, 1, 2'd2, 1, "mid_cnt0");
    cyc(0, 0, 4'b0000, 0, 1, 2'd2, 0, "mid_release");
    cyc(0, 0, 4'b0000, 0, 1, 2'd2, 0, "mid_idle");
    // Reset in the middle of a dwell.
    cyc(0, 1, 4'b0100, 3, 0, 2'd2, 1, "pre_rst_grant");
    cyc(1, 1, 4'b0100, 3, 1, 2'd0, 0, "rst_mid_dwell");
    cyc(0, 1, 4'b0110, 0, 1, 2'd1, 1, "post_rst_ch1");
    cyc(0, 1, 4'b0110, 0, 1, 2'd2, 1, "post_rst_ch2");
    cyc(0, 1, 4'b0110, 0, 1, 2'd1, 1, "post_rst_ch1b");
`endif
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Upstream control stage for the 4-channel, 4-bit mux datapath (bit_4_mux). Instead of a free-running select counter, it chooses which of 4 requesting sources drives the mux. It produces the 2-bit select with a programmable dwell per grant and a valid/ack handshake to the consumer. Round-robin by default.

Parameters:
N_CH, 4, number of mux channels; fixed at 4 for this revision.
SEL_W, 2, select width, equal to log2(N_CH).
DWELL_W, 4, width of the dwell-count input.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  sequencer enable; gates new grants only.
req  input  4  per-channel request, bit i = channel i has data.
dwell  input  DWELL_W  extra hold cycles per grant, sampled at grant time.
ack  input  1  consumer has taken the current selection.
sel  output  SEL_W  mux select, stable while sel_valid=1.
sel_valid  output  1  sel is a live grant.
busy  output  1  high in DWELL state.

Behaviour:
- All state is clocked on the rising edge of clk. rst is synchronous and active-high.
- Reset values: sel=0, sel_valid=0, busy=0, state=IDLE, cnt=0, ptr=3 (so the first search starts at channel 0).
- States:
  - IDLE: sel_valid=0.
  - DWELL: sel_valid=1, busy=1.
- IDLE -> DWELL: when en=1 and |req=1.
  - Grants the first requesting channel at ptr+1, ptr+2, ... mod 4.
  - Registers sel, sets ptr=sel, loads cnt=dwell.
  - Latency: sel_valid rises 1 cycle after the req/en edge.
- In DWELL:
  - sel is held constant.
  - cnt decrements by 1 per cycle while cnt!=0.
  - ack is ignored while cnt!=0.
- Release condition: cnt==0 and ack==1.
  - If en=1 and |req=1: re-grant immediately; the next channel is chosen by round-robin from the updated ptr. There is no IDLE bubble, sel changes on the next edge, and sel_valid stays 1.
  - Otherwise: go to IDLE; sel_valid=0 next cycle; sel keeps its last value.
- Stall: with cnt==0 and ack==0, stay in DWELL indefinitely and keep sel stable.
- Minimum grant length: dwell=0 gives a 1-cycle grant if ack=1 in that cycle. dwell=N gives at least N+1 cycles.
- Wrap-around: ptr=3 searches 0,1,2,3.
- Single requester: the same channel is re-granted back-to-back.
- Current channel's req drops mid-dwell: the grant is not aborted; it completes normally.
- en drops mid-dwell: the current grant completes; no new grant follows.
- rst asserted mid-dwell: reset values apply at the next edge, regardless of ack or cnt.
- Changes to dwell during DWELL have no effect until the next grant.
- No arithmetic overflow: cnt only counts down and saturates at 0.

Optional Feature:
MUX_SEL_SEQ_FIXED_PRIO_EN
- Defined: the round-robin search is replaced by fixed priority; the lowest-index requesting channel always wins. ptr is still updated but ignored.
- Undefined: round-robin as described in Behaviour.
- Handshake and dwell behaviour are identical in both builds.

Decomposition:
- Shared package mux_seq_pkg holds:
  - constants N_CH=4 and SEL_W=2;
  - state typedef with IDLE=1'b0, DWELL=1'b1;
  - PTR_RST=2'd3.
- One combinational sub-module, rr_pick:
  - inputs: req[3:0], ptr[1:0];
  - outputs: pick[1:0], found.
  - The fixed-priority variant lives inside rr_pick under the macro.

Test Plan:
1. Reset, then en=1, req=4'b1111, dwell=0, ack=1 held -> sel goes 0,1,2,3,0 on consecutive cycles; sel_valid=1 throughout from 1 cycle after req.
2. req=4'b0100, dwell=3, ack=1 -> sel=2 for 4 cycles per grant; re-granted back-to-back to channel 2.
3. req=4'b1001, dwell=0, ack=0 for 5 cycles, then 1 -> sel stays 0 for 6 cycles, then moves to 3; then wraps back to 0.
4. Mid-dwell (cnt=2): drop en and req to 0 -> grant finishes on ack; sel_valid=0 the next cycle; sel holds its value.
5. rst pulsed while in DWELL with sel=2 -> next edge: sel=0, sel_valid=0, busy=0. With req=4'b0110 after reset, the first grant is channel 1.
6. With MUX_SEL_SEQ_FIXED_PRIO_EN defined, req=4'b1010, dwell=0, ack=1 -> sel=1 on every grant; channel 3 is never selected.
